// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared types and default 640x480@60 raster timing for the VGA pixel
//   output path (vga_timing_gen and vga_pixel_out).
//   Contents:
//     rgb_t      - 12-bit RGB444 colour {R[11:8],G[7:4],B[3:0]}
//     VGA_*      - default horizontal/vertical timing and sync window bounds
//     vga_ctl_t  - per-pixel control record carried down the alignment pipe
//     in_range() - half-open window decode helper
//   Optional feature macro: VGA_BORDER_EN (adds a border flag to vga_ctl_t).
package vga_pkg;

  typedef logic [11:0] rgb_t;

  // Horizontal timing in pixel ticks.
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_FP         = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BP         = 48;
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

  // Vertical timing in lines.
  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_FP         = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BP         = 33;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Upstream latency (pixel ticks) from x/y out to colour/select back.
  localparam int VGA_PIPE_LAT     = 2;
  localparam int VGA_PIPE_LAT_MAX = 7;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;

  // Everything about a pixel that has to wait for its colour to come back.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
`ifdef VGA_BORDER_EN
    logic border;
`endif
  } vga_ctl_t;

  // Blank, no sync: what the pipe holds after reset.
  localparam vga_ctl_t CTL_IDLE = '0;

  // True when lo <= v < hi.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster counters for the VGA output path. Counts x across a line and y
//   down a frame, advancing only on pix_en ticks, and decodes the current
//   coordinate into active-video and raw sync flags.
//   Optional feature macro: VGA_BORDER_EN adds the o_border decode output.
// Ports
//   i_clk          in   1   system clock
//   i_rst          in   1   synchronous active-high reset
//   i_pix_en       in   1   pixel-rate enable
//   o_x            out  10  horizontal count 0..H_TOTAL-1 (registered)
//   o_y            out  10  vertical count 0..V_TOTAL-1 (registered)
//   o_frame_start  out  1   one-clk pulse after the tick that consumed (0,0)
//   o_active       out  1   (x,y) lies in the visible area
//   o_hs_raw       out  1   x lies inside the horizontal sync window
//   o_vs_raw       out  1   y lies inside the vertical sync window
//   o_border       out  1   (VGA_BORDER_EN only) visible pixel on the edge
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_active,
  output logic       o_hs_raw,
  output logic       o_vs_raw
`ifdef VGA_BORDER_EN
  ,
  output logic       o_border
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_frame_start;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_active;
  logic       w_hs_raw;
  logic       w_vs_raw;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Raster counters and frame-start pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_frame_start <= 1'b0;
    end else begin
      // Pulse is a single clk wide even though pix_en is sparse.
      r_frame_start <= i_pix_en && (r_x == 10'd0) && (r_y == 10'd0);
      if (i_pix_en) begin
        if (w_x_last) begin
          r_x <= 10'd0;
          if (w_y_last) begin
            r_y <= 10'd0;
          end else begin
            r_y <= r_y + 10'd1;
          end
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  // Decode the current coordinate into visibility and sync windows.
  always_comb begin
    w_active = (r_x < X_ACT) && (r_y < Y_ACT);
    w_hs_raw = in_range(r_x, HS_START, HS_END);
    w_vs_raw = in_range(r_y, VS_START, VS_END);
  end

`ifdef VGA_BORDER_EN
  localparam logic [9:0] X_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_ACT_LAST = 10'(V_ACTIVE - 1);

  logic w_border;

  // Outermost ring of the visible area.
  always_comb begin
    w_border = w_active &&
               ((r_x == 10'd0) || (r_x == X_ACT_LAST) ||
                (r_y == 10'd0) || (r_y == Y_ACT_LAST));
  end

  assign o_border = w_border;
`endif

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;
  assign o_active      = w_active;
  assign o_hs_raw      = w_hs_raw;
  assign o_vs_raw      = w_vs_raw;

endmodule

// File: rtl/vga_pixel_out.sv
// vga_pixel_out
//   VGA back end sitting after the 12-bit layer selector. Publishes the
//   current raster coordinate, waits PIPE_LAT pixel ticks for the matching
//   background/foreground/select to come back, then muxes, blanks and
//   registers RGB444 together with HS/VS. Coordinate-to-pin latency is
//   PIPE_LAT+1 pixel ticks. PIPE_LAT is meaningful in 0..7.
//   Optional feature macro: VGA_BORDER_EN forces the outermost visible ring
//   to white, overriding sel.
// Ports
//   i_clk          in   1   system clock
//   i_rst          in   1   synchronous active-high reset
//   i_pix_en       in   1   pixel-rate enable; 0 holds every register
//   i_bg_rgb       in   12  background colour {R,G,B}
//   i_fg_rgb       in   12  foreground colour {R,G,B}
//   i_sel          in   1   1 selects fg, 0 selects bg
//   o_x            out  10  current h count (registered)
//   o_y            out  10  current v count (registered)
//   o_frame_start  out  1   one-clk pulse on the (0,0) tick
//   o_vga_r/g/b    out  4   colour outputs (registered)
//   o_vga_hs       out  1   horizontal sync (registered)
//   o_vga_vs       out  1   vertical sync (registered)
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_LAT = VGA_PIPE_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_en,
  input  logic [11:0] i_bg_rgb,
  input  logic [11:0] i_fg_rgb,
  input  logic        i_sel,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs
);

  logic [9:0] w_x;
  logic [9:0] w_y;
  logic       w_frame_start;
  logic       w_active;
  logic       w_hs_raw;
  logic       w_vs_raw;
`ifdef VGA_BORDER_EN
  logic       w_border;
`endif

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pix_en      (i_pix_en),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_start (w_frame_start),
    .o_active      (w_active),
    .o_hs_raw      (w_hs_raw),
    .o_vs_raw      (w_vs_raw)
`ifdef VGA_BORDER_EN
    ,
    .o_border      (w_border)
`endif
  );

  vga_ctl_t w_ctl_raw;
  vga_ctl_t w_ctl_d;

  // Bundle the raw decodes for the current coordinate.
  always_comb begin
    w_ctl_raw        = CTL_IDLE;
    w_ctl_raw.active = w_active;
    w_ctl_raw.hs     = w_hs_raw;
    w_ctl_raw.vs     = w_vs_raw;
`ifdef VGA_BORDER_EN
    w_ctl_raw.border = w_border;
`endif
  end

  // The control flags wait here until the upstream colour for the same
  // coordinate arrives; clearing on reset keeps stale sync out of the pins.
  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign w_ctl_d = w_ctl_raw;
    end else begin : g_pipe
      vga_ctl_t r_pipe [PIPE_LAT];

      // pix_en-gated shift register of control records.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            r_pipe[i] <= CTL_IDLE;
          end
        end else if (i_pix_en) begin
          r_pipe[0] <= w_ctl_raw;
          for (int i = 1; i < PIPE_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_ctl_d = r_pipe[PIPE_LAT-1];
    end
  endgenerate

  rgb_t w_pix_rgb;

  // Colour select; sel only matters inside the visible area.
  always_comb begin
    w_pix_rgb = RGB_BLACK;
    if (w_ctl_d.active) begin
`ifdef VGA_BORDER_EN
      if (w_ctl_d.border) begin
        w_pix_rgb = RGB_WHITE;
      end else if (i_sel) begin
        w_pix_rgb = i_fg_rgb;
      end else begin
        w_pix_rgb = i_bg_rgb;
      end
`else
      if (i_sel) begin
        w_pix_rgb = i_fg_rgb;
      end else begin
        w_pix_rgb = i_bg_rgb;
      end
`endif
    end else begin
      w_pix_rgb = RGB_BLACK;
    end
  end

  rgb_t r_rgb;
  logic r_hs;
  logic r_vs;

  // Output register: colour and sync leave together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb <= RGB_BLACK;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
    end else if (i_pix_en) begin
      r_rgb <= w_pix_rgb;
      r_hs  <= w_ctl_d.hs ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_ctl_d.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_x           = w_x;
  assign o_y           = w_y;
  assign o_frame_start = w_frame_start;
  assign o_vga_r       = r_rgb[11:8];
  assign o_vga_g       = r_rgb[7:4];
  assign o_vga_b       = r_rgb[3:0];
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: a full-size 640x480 instance (A) and a tiny-raster
// instance (B, 16x9 totals) so frame wrap and vertical sync fit in a short run.
// Both share stimulus; pix_en is high one clk in four.
module tb_vga_pixel_out;

  localparam int LAT = 2;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } out_t;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] bg;
    logic [11:0] fg;
    logic        sel;
    logic [11:0] exp_rgb;
  } vec_t;

  logic        clk, rst, pix_en, sel;
  logic [11:0] bg, fg;
  logic [9:0]  xa, ya, xb, yb;
  logic        fsa, fsb, hsa, hsb, vsa, vsb;
  logic [3:0]  ra, ga, ba, rb, gb, bb;
  out_t        got_a, got_b, exp_a, exp_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;
  vec_t vecs [10];

  assign got_a = {xa, ya, fsa, ra, ga, ba, hsa, vsa};
  assign got_b = {xb, yb, fsb, rb, gb, bb, hsb, vsb};

  vga_pixel_out #(.PIPE_LAT(LAT)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en), .i_bg_rgb(bg), .i_fg_rgb(fg),
    .i_sel(sel), .o_x(xa), .o_y(ya), .o_frame_start(fsa), .o_vga_r(ra),
    .o_vga_g(ga), .o_vga_b(ba), .o_vga_hs(hsa), .o_vga_vs(vsa));

  vga_pixel_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
                  .PIPE_LAT(LAT)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en), .i_bg_rgb(bg), .i_fg_rgb(fg),
    .i_sel(sel), .o_x(xb), .o_y(yb), .o_frame_start(fsb), .o_vga_r(rb),
    .o_vga_g(gb), .o_vga_b(bb), .o_vga_hs(hsb), .o_vga_vs(vsb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // Reference: outputs after a clk edge, from the tick count since reset.
  // Pin output after tick n shows pixel n-1-LAT; input colour during the
  // interval before a tick belongs to pixel (ticks so far)-LAT.
  function automatic out_t model_next(input int ha, hf, hsy, hb, va, vf, vsy, vb,
                                      input logic rst_v, pe_v,
                                      input logic [11:0] bg_v, fg_v,
                                      input logic sel_v, input int c,
                                      input out_t prev);
    out_t e;
    int ht, vt, fr, q, qx, qy, n;
    bit act, brd;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    fr = ht * vt;
    e = prev;
    e.fs = 1'b0;
    if (rst_v) begin
      e.x = 10'd0; e.y = 10'd0; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    end else if (pe_v) begin
      n = c + 1;
      e.x = 10'(n % ht);
      e.y = 10'((n / ht) % vt);
      e.fs = ((c % fr) == 0);
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
      if (c >= LAT) begin
        q = (c - LAT) % fr;
        qx = q % ht;
        qy = q / ht;
        act = (qx < ha) && (qy < va);
        brd = BORDER && (qx == 0 || qx == ha - 1 || qy == 0 || qy == va - 1);
        if (act) e.rgb = brd ? 12'hFFF : (sel_v ? fg_v : bg_v);
        e.hs = !(qx >= ha + hf && qx < ha + hf + hsy);
        e.vs = !(qy >= va + vf && qy < va + vf + vsy);
      end
    end
    return e;
  endfunction

  task automatic check_out(input string nm, input out_t g, input out_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t tick=%0d got x=%0d y=%0d fs=%b rgb=%03h hs=%b vs=%b, expected x=%0d y=%0d fs=%b rgb=%03h hs=%b vs=%b",
               nm, $time, cnt, g.x, g.y, g.fs, g.rgb, g.hs, g.vs, e.x, e.y, e.fs, e.rgb, e.hs, e.vs);
    end
  endtask

  task automatic check_eq(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", nm, $time, g, e);
    end
  endtask

  function automatic int find_vec(input int px, input int py);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].x == px && vecs[i].y == py) return i;
    end
    return -1;
  endfunction

  // One clk: apply pix_en, advance the model at the edge, compare #1 later.
  task automatic clk_step(input logic pe);
    pix_en = pe;
    @(posedge clk);
    exp_a = model_next(640, 16, 96, 48, 480, 10, 2, 33, rst, pix_en, bg, fg, sel, cnt, exp_a);
    exp_b = model_next(8, 2, 3, 3, 4, 1, 2, 2, rst, pix_en, bg, fg, sel, cnt, exp_b);
    if (rst) cnt = 0;
    else if (pix_en) cnt++;
    #1;
    check_out("outA", got_a, exp_a);
    check_out("outB", got_b, exp_b);
  endtask

  // Upstream: colour for pixel cnt-LAT, from the vector table or random.
  task automatic drive_inputs();
    int q, k;
    bg  = 12'($urandom);
    fg  = 12'($urandom);
    sel = 1'($urandom);
    if (cnt >= LAT) begin
      q = (cnt - LAT) % 420000;
      k = find_vec(q % 800, q / 800);
      if (k >= 0) begin
        bg = vecs[k].bg; fg = vecs[k].fg; sel = vecs[k].sel;
      end
    end
  endtask

  int  hs_start = -1, hs_len = 0, vs_start = -1, vs_len = 0;
  int  fs_a_cnt = 0, fs_b_cnt = 0;
  bit  mon_done = 1'b0;

  task automatic tick();
    int p, k;
    clk_step(1'b0); clk_step(1'b0); clk_step(1'b0); clk_step(1'b1);
    if (cnt >= LAT + 1) begin
      p = cnt - LAT - 1;
      k = find_vec(p % 800, p / 800);
      if (k >= 0) check_eq($sformatf("vec%0d_rgb", k), 32'({ra, ga, ba}), 32'(vecs[k].exp_rgb));
    end
    if (!mon_done) begin
      if (!hsa) begin
        if (hs_start < 0) hs_start = cnt;
        hs_len++;
      end
      if (cnt <= 144 && !vsb) begin
        if (vs_start < 0) vs_start = cnt;
        vs_len++;
      end
      if (fsa) fs_a_cnt++;
      if (fsb) fs_b_cnt++;
      if (cnt == 800) begin
        check_eq("hs_start_tick", 32'(hs_start), 32'(656 + LAT + 1));
        check_eq("hs_len_ticks", 32'(hs_len), 32'd96);
        check_eq("vsB_start_tick", 32'(vs_start), 32'(5 * 16 + LAT + 1));
        check_eq("vsB_len_ticks", 32'(vs_len), 32'd32);
        check_eq("fsA_pulses", 32'(fs_a_cnt), 32'd1);
        check_eq("fsB_pulses", 32'(fs_b_cnt), 32'd6);
        mon_done = 1'b1;
      end
    end
    drive_inputs();
  endtask

  task automatic stall();
    logic [11:0] sb, sf;
    logic ss;
    sb = bg; sf = fg; ss = sel;
    for (int i = 0; i < 10; i++) begin
      bg = 12'($urandom); fg = 12'($urandom); sel = 1'($urandom);
      clk_step(1'b0);
    end
    bg = sb; fg = sf; sel = ss;
  endtask

  initial begin
    vecs[0] = '{0,   0, 12'h0A0, 12'h000, 1'b0, BORDER ? 12'hFFF : 12'h0A0};
    vecs[1] = '{1,   0, 12'h0A0, 12'hFFF, 1'b1, 12'hFFF};
    vecs[2] = '{640, 0, 12'hFFF, 12'h000, 1'b0, 12'h000};
    vecs[3] = '{700, 0, 12'hFFF, 12'hFFF, 1'b1, 12'h000};
    vecs[4] = '{639, 1, 12'h0A0, 12'h123, 1'b1, BORDER ? 12'hFFF : 12'h123};
    vecs[5] = '{300, 3, 12'h456, 12'h789, 1'b1, 12'h789};
    vecs[6] = '{300, 4, 12'h456, 12'h789, 1'b0, 12'h456};
    vecs[7] = '{0,   5, 12'h0A0, 12'h000, 1'b0, BORDER ? 12'hFFF : 12'h0A0};
    vecs[8] = '{639, 5, 12'h0A0, 12'h000, 1'b0, BORDER ? 12'hFFF : 12'h0A0};
    vecs[9] = '{5,   5, 12'h0A0, 12'h000, 1'b0, 12'h0A0};

    rst = 1'b1; pix_en = 1'b0; bg = 12'h000; fg = 12'h000; sel = 1'b0;
    exp_a = '0; exp_b = '0;
    clk_step(1'b0); clk_step(1'b1); clk_step(1'b0);
    check_eq("rst_x", 32'(xa), 32'd0);
    check_eq("rst_y", 32'(ya), 32'd0);
    check_eq("rst_rgb", 32'({ra, ga, ba}), 32'd0);
    check_eq("rst_hs", 32'(hsa), 32'd1);
    check_eq("rst_vs", 32'(vsa), 32'd1);
    check_eq("rst_fs", 32'(fsa), 32'd0);
    rst = 1'b0;
    drive_inputs();

    while (cnt < 5500) begin
      tick();
      if (cnt == 1000) stall();
    end

    // Reset in the middle of line 6 while hs is low at the pins.
    check_eq("pre_rst_hs_low", 32'(hsa), 32'd0);
    rst = 1'b1;
    clk_step(1'b0);
    check_eq("midrst_x", 32'(xa), 32'd0);
    check_eq("midrst_y", 32'(ya), 32'd0);
    check_eq("midrst_rgb", 32'({ra, ga, ba}), 32'd0);
    check_eq("midrst_hs", 32'(hsa), 32'd1);
    rst = 1'b0;
    drive_inputs();
    while (cnt < 900) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
